// File: rtl/regex_stream_ctx.sv
// regex_stream_ctx: per-stream context wrapper around one external DFA matcher.
// Saves and restores the DFA state per stream ID, registers the DFA interface,
// tracks per-packet match status and keeps a saturating match count.
//
// Handshake/strobe semantics: every *_vld / strobe here is a single-cycle
// qualifier with no back-pressure. Data is meaningful only in a cycle where its
// strobe is high. The producer never waits on the consumer, and nothing stalls.
module regex_stream_ctx #(
    parameter int STATE_W = 11,
    parameter int SID_W   = 6,
    parameter int COUNT_W = 16,
    parameter int MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               load_state,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               eop,
    input  logic               enable,
    input  logic               clear_count,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_load,
    output logic               dfa_state_load_vld,
    input  logic [STATE_W-1:0] dfa_state,
    input  logic               dfa_accept,
    output logic [COUNT_W-1:0] count,
    output logic               fired,
    output logic [COUNT_W-1:0] pkt_hits
);

    localparam int NUM_STREAMS = 2 ** SID_W;

    // Saturating add: all-ones is sticky and the sum never wraps.
    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    endfunction

    // Context storage: state per stream plus a valid bit. The memory has no reset.
    // A stream whose valid bit is clear restores from state 0.
    logic [STATE_W-1:0]     mem [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] vbits;

    // Registered DFA outputs.
    logic [STATE_W-1:0]     dfa_state_r;
    logic                   dfa_accept_r;

    // Stream of the packet currently open. It is latched at load_state so that an
    // eop coinciding with the next packet's load still addresses the old stream.
    logic [SID_W-1:0]       pkt_sid;

    // Restore pipeline, stage 1 (memory read register).
    logic [STATE_W-1:0]     rd_val_q;
    logic                   rd_vld_q;

    // Combinational helpers.
    logic                   save_en;
    logic [STATE_W-1:0]     restore_val;
    logic [COUNT_W-1:0]     one_cnt;
    logic [COUNT_W-1:0]     hits_eff;
    logic [COUNT_W-1:0]     count_add;
    logic [COUNT_W-1:0]     count_base;
    logic [COUNT_W-1:0]     count_next;
    logic [COUNT_W-1:0]     hits_inc;

    assign save_en = eop & enable;
    assign one_cnt = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Select the restore value. A save to the same stream in this very cycle
    // bypasses the memory. A save one cycle earlier is already in mem.
    always_comb begin
        restore_val = '0;
        if (new_stream_id) begin
            restore_val = '0;
        end else if (save_en && (pkt_sid == stream_id)) begin
            restore_val = dfa_state_r;
        end else if (vbits[stream_id]) begin
            restore_val = mem[stream_id];
        end
    end

    // End-of-packet count contribution and next count value.
    always_comb begin
        hits_eff   = sat_add(pkt_hits, dfa_accept_r ? one_cnt : '0);
        count_add  = '0;
        if (MODE == 0) begin
            count_add = (fired | dfa_accept_r) ? one_cnt : '0;
        end else begin
            count_add = hits_eff;
        end
        count_base = clear_count ? '0 : count;
        count_next = sat_add(count_base, count_add);
        hits_inc   = sat_add(pkt_hits, one_cnt);
    end

    // Capture DFA state every cycle; the data path needs no reset.
    always_ff @(posedge clk) begin
        dfa_state_r <= dfa_state;
    end

    // Capture DFA accept every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dfa_accept_r <= 1'b0;
        end else begin
            dfa_accept_r <= dfa_accept;
        end
    end

    // Character data register towards the DFA. The data is don't-care after reset.
    always_ff @(posedge clk) begin
        dfa_char <= char_in;
    end

    // Character strobe register towards the DFA.
    always_ff @(posedge clk) begin
        if (rst) begin
            dfa_char_vld <= 1'b0;
        end else begin
            dfa_char_vld <= char_in_vld;
        end
    end

    // Save the DFA state of the open packet on an enabled eop.
    always_ff @(posedge clk) begin
        if (save_en) begin
            mem[pkt_sid] <= dfa_state_r;
        end
    end

    // Per-stream valid bits: set on save, wiped by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vbits <= '0;
        end else if (save_en) begin
            vbits[pkt_sid] <= 1'b1;
        end
    end

    // Latch the stream of the packet being opened.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_sid <= '0;
        end else if (load_state) begin
            pkt_sid <= stream_id;
        end
    end

    // Restore stage 1: register the selected value and the load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_val_q <= '0;
        end else begin
            rd_vld_q <= load_state;
            if (load_state) begin
                rd_val_q <= restore_val;
            end
        end
    end

    // Restore stage 2: output register towards the DFA. It is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dfa_state_load_vld <= 1'b0;
            dfa_state_load     <= '0;
        end else begin
            dfa_state_load_vld <= rd_vld_q;
            if (rd_vld_q) begin
                dfa_state_load <= rd_val_q;
            end
        end
    end

    // Per-packet flag and hit counter. An accept in the same cycle as a clear
    // (load, or disabled eop) wins and counts as the first hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            fired    <= 1'b0;
            pkt_hits <= '0;
        end else if (dfa_accept_r) begin
            fired    <= 1'b1;
            pkt_hits <= (load_state || (eop && !enable)) ? one_cnt : hits_inc;
        end else if (load_state || (eop && !enable)) begin
            fired    <= 1'b0;
            pkt_hits <= '0;
        end
    end

    // Saturating match count. When clear_count meets an enabled eop, the count
    // becomes the eop contribution alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (save_en) begin
            count <= count_next;
        end else if (clear_count) begin
            count <= '0;
        end
    end

endmodule

// File: tb/tb_regex_stream_ctx.sv
// Bench for regex_stream_ctx. It runs four instances on shared stimulus:
// MODE 0 and MODE 1 at COUNT_W=16, and MODE 1 and MODE 0 at COUNT_W=4 for
// saturation corners.
module tb_regex_stream_ctx;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_in_vld;
  logic        load_state;
  logic [5:0]  stream_id;
  logic        new_stream_id;
  logic        eop;
  logic        enable;
  logic        clear_count;
  logic [10:0] dfa_state;
  logic        dfa_accept;

  logic [7:0]  dch [NI];
  logic [10:0] sld [NI];
  logic [15:0] cnt [NI];
  logic [15:0] hits [NI];
  logic [NI-1:0] dcv, slv, fir;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Scoreboard for the restore path: {due cycle, expected load value}.
  logic [42:0] exp_q[$];

  // Bench model of the context and counters.
  logic [10:0] exp_mem [64];
  bit          exp_v [64];
  int          exp_cnt [NI];
  int          cmax [NI]  = '{65535, 65535, 15, 15};
  int          cmode [NI] = '{0, 1, 1, 0};
  int          pkt_acc;
  int          m_sid;

  typedef struct {
    logic [7:0] ch;
    logic       vld;
    logic [7:0] exp_ch;
    logic       exp_vld;
  } char_vec_t;
  char_vec_t cv [8];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = (g < 2) ? 16 : 4;
    localparam int MD = (g == 1 || g == 2) ? 1 : 0;
    logic [CW-1:0] c_w, h_w;
    regex_stream_ctx #(.STATE_W(11), .SID_W(6), .COUNT_W(CW), .MODE(MD)) u_dut (
      .clk(clk), .rst(rst), .char_in(char_in), .char_in_vld(char_in_vld),
      .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
      .eop(eop), .enable(enable), .clear_count(clear_count),
      .dfa_char(dch[g]), .dfa_char_vld(dcv[g]),
      .dfa_state_load(sld[g]), .dfa_state_load_vld(slv[g]),
      .dfa_state(dfa_state), .dfa_accept(dfa_accept),
      .count(c_w), .fired(fir[g]), .pkt_hits(h_w)
    );
    assign cnt[g]  = 16'(c_w);
    assign hits[g] = 16'(h_w);
  end

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Restore-path monitor: pop an expectation whenever a load strobe shows up.
  always @(negedge clk) begin
    if (slv !== 4'b0000 && slv !== 4'bxxxx) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL restore_unexpected: got vld %b expected none (t=%0t)", slv, $time);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        chk("restore_latency", cyc, int'(e[42:11]));
        for (int g = 0; g < NI; g++) begin
          chk("restore_vld", int'(slv[g]), 1);
          chk("restore_val", int'(sld[g]), int'(e[10:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic accept(input int n);
    dfa_accept = 1'b1;
    repeat (n) tick();
    dfa_accept = 1'b0;
    pkt_acc += n;
  endtask

  // One control cycle: any mix of load, eop and clear, with model update.
  task automatic cycle(input bit ld, input int sid, input bit nw,
                       input bit ep, input bit en, input bit clr);
    logic [10:0] ev;
    int base, add;
    load_state = ld; stream_id = sid[5:0]; new_stream_id = nw;
    eop = ep; enable = en; clear_count = clr;
    for (int g = 0; g < NI; g++) begin
      base = clr ? 0 : exp_cnt[g];
      if (ep && en) begin
        add = cmode[g] ? ((pkt_acc > cmax[g]) ? cmax[g] : pkt_acc) : ((pkt_acc > 0) ? 1 : 0);
        exp_cnt[g] = (base + add > cmax[g]) ? cmax[g] : base + add;
      end else begin
        exp_cnt[g] = base;
      end
    end
    if (ep && en) begin
      exp_mem[m_sid] = dfa_state;
      exp_v[m_sid] = 1'b1;
    end
    if (ep && !en) pkt_acc = 0;
    if (ld) begin
      ev = nw ? 11'h0 : (exp_v[sid] ? exp_mem[sid] : 11'h0);
      exp_q.push_back({32'(cyc + 2), ev});
      m_sid = sid;
      pkt_acc = 0;
    end
    tick();
    load_state = 1'b0; new_stream_id = 1'b0; eop = 1'b0;
    enable = 1'b0; clear_count = 1'b0;
  endtask

  task automatic chk_counts(input string name);
    for (int g = 0; g < NI; g++) chk(name, int'(cnt[g]), exp_cnt[g]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) exp_v[i] = 1'b0;
    for (int g = 0; g < NI; g++) exp_cnt[g] = 0;
    pkt_acc = 0;
    m_sid = 0;
  endtask

  initial begin
    rst = 1'b1; char_in = 8'h00; char_in_vld = 1'b0; load_state = 1'b0;
    stream_id = 6'd0; new_stream_id = 1'b0; eop = 1'b0; enable = 1'b0;
    clear_count = 1'b0; dfa_state = 11'h000; dfa_accept = 1'b0;
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state.
    for (int g = 0; g < NI; g++) begin
      chk("rst_count", int'(cnt[g]), 0);
      chk("rst_fired", int'(fir[g]), 0);
      chk("rst_hits", int'(hits[g]), 0);
      chk("rst_char_vld", int'(dcv[g]), 0);
      chk("rst_load_vld", int'(slv[g]), 0);
    end

    // Char path: table-driven, one-cycle latency.
    cv[0] = '{8'h41, 1'b1, 8'h41, 1'b1};
    cv[1] = '{8'h00, 1'b1, 8'h00, 1'b1};
    cv[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    cv[3] = '{8'h5A, 1'b1, 8'h5A, 1'b1};
    cv[4] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    cv[5] = '{8'h80, 1'b0, 8'h80, 1'b0};
    cv[6] = '{8'h01, 1'b1, 8'h01, 1'b1};
    cv[7] = '{8'h7E, 1'b0, 8'h7E, 1'b0};
    for (int i = 0; i < 8; i++) begin
      char_in = cv[i].ch;
      char_in_vld = cv[i].vld;
      tick();
      chk("char_data", int'(dch[0]), int'(cv[i].exp_ch));
      chk("char_vld", int'(dcv[0]), int'(cv[i].exp_vld));
      chk("char_vld_m1", int'(dcv[1]), int'(cv[i].exp_vld));
    end
    char_in_vld = 1'b0;

    // Restore of a never-saved stream gives state 0.
    cycle(1, 5, 0, 0, 0, 0);
    idle(3);

    // Packet on sid 3 with one accept, saved and restored.
    cycle(1, 3, 1, 0, 0, 0);
    dfa_state = 11'h1A5;
    idle(2);
    accept(1);
    idle(3);
    chk("fired_set", int'(fir[0]), 1);
    chk("hits_one", int'(hits[0]), 1);
    cycle(0, 3, 0, 1, 1, 0);
    chk_counts("count_first");
    cycle(1, 3, 0, 0, 0, 0);
    idle(3);

    // Three accepts: MODE 1 adds 3, MODE 0 adds 1.
    cycle(1, 4, 1, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      accept(1);
      idle(1);
    end
    idle(2);
    chk("hits_three_m0", int'(hits[0]), 3);
    chk("hits_three_m1", int'(hits[1]), 3);
    cycle(0, 4, 0, 1, 1, 0);
    chk_counts("count_three");

    // Disabled eop: flags cleared, no count, no save.
    cycle(1, 3, 0, 0, 0, 0);
    dfa_state = 11'h055;
    idle(1);
    accept(1);
    idle(3);
    chk("fired_before_dis", int'(fir[0]), 1);
    cycle(0, 3, 0, 1, 0, 0);
    chk("fired_dis", int'(fir[0]), 0);
    chk("hits_dis", int'(hits[1]), 0);
    chk_counts("count_dis");
    cycle(1, 3, 0, 0, 0, 0);
    idle(3);

    // clear_count together with an enabled matching eop.
    cycle(1, 9, 1, 0, 0, 0);
    idle(1);
    accept(1);
    idle(3);
    cycle(0, 9, 0, 1, 1, 1);
    chk_counts("count_clear_eop");
    cycle(0, 9, 0, 0, 0, 1);
    chk_counts("count_clear");

    // Bypass: save to sid 7 with a load of sid 7 in the same and the next cycle.
    cycle(1, 7, 1, 0, 0, 0);
    dfa_state = 11'h0F0;
    idle(2);
    cycle(1, 7, 0, 1, 1, 0);
    cycle(1, 7, 0, 0, 0, 0);
    idle(2);

    // Back-to-back on different streams: eop saves the old stream.
    dfa_state = 11'h2AB;
    idle(1);
    accept(1);
    idle(3);
    cycle(1, 10, 0, 1, 1, 0);
    chk_counts("count_b2b");
    idle(2);
    cycle(1, 7, 0, 0, 0, 0);
    idle(3);

    // Saturation on the 4-bit instances.
    for (int p = 0; p < 17; p++) begin
      cycle(1, 1, 1, 0, 0, 0);
      idle(1);
      accept(1);
      idle(3);
      cycle(0, 1, 0, 1, 1, 0);
    end
    chk_counts("count_sat");
    cycle(1, 1, 1, 0, 0, 0);
    idle(1);
    accept(20);
    idle(3);
    chk("hits_sat_w4", int'(hits[2]), 15);
    chk("hits_twenty", int'(hits[0]), 20);
    cycle(0, 1, 0, 1, 1, 0);
    chk_counts("count_sat_hits");
    idle(3);

    // Reset mid-packet wipes counters and valid bits.
    cycle(1, 2, 1, 0, 0, 0);
    idle(1);
    accept(1);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int g = 0; g < NI; g++) begin
      chk("midrst_count", int'(cnt[g]), 0);
      chk("midrst_fired", int'(fir[g]), 0);
      chk("midrst_hits", int'(hits[g]), 0);
    end
    cycle(1, 7, 0, 0, 0, 0);
    idle(4);

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
